// File: rtl/floating_point_check_pkg.sv
// Shared types and IEEE-754 single-precision field constants for the result checker.
package floating_point_check_pkg;

    localparam int unsigned FP_W     = 32;
    localparam int unsigned SIGN_POS = 31;
    localparam int unsigned EXP_MSB  = 30;
    localparam int unsigned EXP_LSB  = 23;
    localparam int unsigned MANT_MSB = 22;
    localparam int unsigned MANT_LSB = 0;
    localparam int unsigned MAG_W    = 31;

    localparam logic [7:0]  EXP_MAX  = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/floating_point_ulp_compare.sv
// Combinational FP32 equivalence test with ULP tolerance.
//   a, b   : IEEE-754 single-precision operands
//   match  : 1 when the operands are considered equal
module floating_point_ulp_compare
    import floating_point_check_pkg::*;
#(
    parameter int unsigned ULP_TOL = 0
) (
    input  logic [FP_W-1:0] a,
    input  logic [FP_W-1:0] b,
    output logic            match
);

    logic             w_a_exp_max;
    logic             w_b_exp_max;
    logic             w_a_nan;
    logic             w_b_nan;
    logic [MAG_W-1:0] w_mag_a;
    logic [MAG_W-1:0] w_mag_b;
    logic [MAG_W-1:0] w_diff;
    logic             w_within;

    assign w_a_exp_max = (a[EXP_MSB:EXP_LSB] == EXP_MAX);
    assign w_b_exp_max = (b[EXP_MSB:EXP_LSB] == EXP_MAX);
    assign w_a_nan     = w_a_exp_max && (a[MANT_MSB:MANT_LSB] != '0);
    assign w_b_nan     = w_b_exp_max && (b[MANT_MSB:MANT_LSB] != '0);
    assign w_mag_a     = a[MAG_W-1:0];
    assign w_mag_b     = b[MAG_W-1:0];

    // Sign-magnitude encoding makes adjacent magnitudes exactly one ULP apart.
    always_comb begin
        w_diff = '0;
        if (w_mag_a >= w_mag_b) begin
            w_diff = w_mag_a - w_mag_b;
        end else begin
            w_diff = w_mag_b - w_mag_a;
        end
    end

    assign w_within = ({1'b0, w_diff} <= ULP_TOL);

    // Inf only ever matches through bit-identity; NaN/Inf are excluded from the ULP path.
    assign match = (a == b)
                 || (w_a_nan && w_b_nan)
                 || ((w_mag_a == '0) && (w_mag_b == '0))
                 || ((a[SIGN_POS] == b[SIGN_POS]) && !w_a_exp_max && !w_b_exp_max && w_within);

endmodule

// File: rtl/floating_point_result_checker.sv
// Streams FP32 results from a core and checks them against a golden ROM.
//   clk, rst_n        : clock, synchronous active-low reset
//   start             : pulse that begins a run (ignored while running)
//   s_tvalid, s_tdata : result beats, no backpressure
//   gold_addr/data    : golden ROM port, data one cycle after address
//   busy, done, pass  : run status
//   err_cnt           : saturating mismatch count
//   first_err_idx/_valid : beat index of first mismatch
//   timeout           : run aborted by idle timeout
module floating_point_result_checker
    import floating_point_check_pkg::*;
#(
    parameter int unsigned DEPTH   = 32,
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned ULP_TOL = 0,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              s_tvalid,
    input  logic [FP_W-1:0]   s_tdata,
    output logic [ADDR_W-1:0] gold_addr,
    input  logic [FP_W-1:0]   gold_data,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W:0]   err_cnt,
    output logic [ADDR_W-1:0] first_err_idx,
    output logic              first_err_valid,
    output logic              timeout
);

    localparam int unsigned CNT_W  = ADDR_W + 1;
    localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);

    localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX    = CNT_W'(DEPTH);
    localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(TIMEOUT);

    state_t              r_state,       w_state_nxt;
    logic [ADDR_W-1:0]   r_idx,         w_idx_nxt;
    logic                r_rx_done,     w_rx_done_nxt;
    logic                r_s1_valid,    w_s1_valid_nxt;
    logic [FP_W-1:0]     r_s1_data,     w_s1_data_nxt;
    logic [ADDR_W-1:0]   r_s1_idx,      w_s1_idx_nxt;
    logic [IDLE_W-1:0]   r_idle_cnt,    w_idle_cnt_nxt;
    logic [CNT_W-1:0]    r_err_cnt,     w_err_cnt_nxt;
    logic [ADDR_W-1:0]   r_first_idx,   w_first_idx_nxt;
    logic                r_first_valid, w_first_valid_nxt;
    logic                r_timeout,     w_timeout_nxt;
    logic                r_done,        w_done_nxt;
    logic                r_pass,        w_pass_nxt;
    logic                r_busy,        w_busy_nxt;

    logic                w_match;
    logic                w_accept;
    logic                w_finish;

    floating_point_ulp_compare #(
        .ULP_TOL (ULP_TOL)
    ) u_cmp (
        .a     (r_s1_data),
        .b     (gold_data),
        .match (w_match)
    );

    assign w_accept = (r_state == ST_RUN) && s_tvalid && !r_rx_done;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, capture stage and compare stage.
    always_comb begin
        w_state_nxt       = r_state;
        w_idx_nxt         = r_idx;
        w_rx_done_nxt     = r_rx_done;
        w_s1_valid_nxt    = 1'b0;
        w_s1_data_nxt     = r_s1_data;
        w_s1_idx_nxt      = r_s1_idx;
        w_idle_cnt_nxt    = r_idle_cnt;
        w_err_cnt_nxt     = r_err_cnt;
        w_first_idx_nxt   = r_first_idx;
        w_first_valid_nxt = r_first_valid;
        w_timeout_nxt     = r_timeout;
        w_done_nxt        = r_done;
        w_pass_nxt        = r_pass;
        w_finish          = 1'b0;

        // Compare stage runs regardless of state so an in-flight beat always lands.
        if (r_s1_valid && !w_match) begin
            if (r_err_cnt != CNT_MAX) begin
                w_err_cnt_nxt = r_err_cnt + CNT_W'(1);
            end
            if (!r_first_valid) begin
                w_first_idx_nxt   = r_s1_idx;
                w_first_valid_nxt = 1'b1;
            end
        end

        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_state_nxt       = ST_RUN;
                    w_idx_nxt         = '0;
                    w_rx_done_nxt     = 1'b0;
                    w_idle_cnt_nxt    = '0;
                    w_err_cnt_nxt     = '0;
                    w_first_idx_nxt   = '0;
                    w_first_valid_nxt = 1'b0;
                    w_timeout_nxt     = 1'b0;
                    w_done_nxt        = 1'b0;
                    w_pass_nxt        = 1'b0;
                end
            end
            ST_RUN: begin
                if (w_accept) begin
                    w_s1_valid_nxt = 1'b1;
                    w_s1_data_nxt  = s_tdata;
                    w_s1_idx_nxt   = r_idx;
                    w_idle_cnt_nxt = '0;
                    if (r_idx == LAST_IDX) begin
                        w_idx_nxt     = '0;
                        w_rx_done_nxt = 1'b1;
                    end else begin
                        w_idx_nxt = r_idx + ADDR_W'(1);
                    end
                end else begin
                    w_idle_cnt_nxt = r_idle_cnt + IDLE_W'(1);
                end

                if (r_s1_valid && (r_s1_idx == LAST_IDX)) begin
                    w_finish = 1'b1;
                end else if (!w_accept && (w_idle_cnt_nxt == IDLE_LIMIT)) begin
                    w_finish      = 1'b1;
                    w_timeout_nxt = 1'b1;
                end

                if (w_finish) begin
                    w_state_nxt = ST_DONE;
                    w_done_nxt  = 1'b1;
                    w_pass_nxt  = (w_err_cnt_nxt == '0) && !w_timeout_nxt;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt == ST_RUN) || w_s1_valid_nxt;
    end

    // Datapath and status registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx         <= '0;
            r_rx_done     <= 1'b0;
            r_s1_valid    <= 1'b0;
            r_s1_data     <= '0;
            r_s1_idx      <= '0;
            r_idle_cnt    <= '0;
            r_err_cnt     <= '0;
            r_first_idx   <= '0;
            r_first_valid <= 1'b0;
            r_timeout     <= 1'b0;
            r_done        <= 1'b0;
            r_pass        <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_idx         <= w_idx_nxt;
            r_rx_done     <= w_rx_done_nxt;
            r_s1_valid    <= w_s1_valid_nxt;
            r_s1_data     <= w_s1_data_nxt;
            r_s1_idx      <= w_s1_idx_nxt;
            r_idle_cnt    <= w_idle_cnt_nxt;
            r_err_cnt     <= w_err_cnt_nxt;
            r_first_idx   <= w_first_idx_nxt;
            r_first_valid <= w_first_valid_nxt;
            r_timeout     <= w_timeout_nxt;
            r_done        <= w_done_nxt;
            r_pass        <= w_pass_nxt;
            r_busy        <= w_busy_nxt;
        end
    end

    assign gold_addr       = r_idx;
    assign busy            = r_busy;
    assign done            = r_done;
    assign pass            = r_pass;
    assign err_cnt         = r_err_cnt;
    assign first_err_idx   = r_first_idx;
    assign first_err_valid = r_first_valid;
    assign timeout         = r_timeout;

endmodule

// File: doc/floating_point_result_checker.md
FLOATING_POINT_RESULT_CHECKER -- requirements
Module: floating_point_result_checker

Interface
REQ-001 SHALL have parameter DEPTH, default 32, number of result beats per test run.
REQ-002 SHALL have parameter ADDR_W, default 5, golden-ROM address width (clog2 of DEPTH).
REQ-003 SHALL have parameter ULP_TOL, default 0, maximum allowed magnitude difference in ULPs.
REQ-004 SHALL have parameter TIMEOUT, default 1024, maximum idle cycles between beats during a run.
REQ-005 clk  in  1  clock; all logic rising-edge.
REQ-006 rst_n  in  1  reset, synchronous, active-low.
REQ-007 start  in  1  single-cycle pulse that begins a run.
REQ-008 s_tvalid  in  1  result beat valid from the floating-point core; no backpressure.
REQ-009 s_tdata  in  32  IEEE-754 single-precision result.
REQ-010 gold_addr  out  ADDR_W  golden-ROM read address.
REQ-011 gold_data  in  32  golden-ROM data, valid exactly one cycle after gold_addr.
REQ-012 busy  out  1  run in progress.
REQ-013 done  out  1  run finished, either completed or timed out.
REQ-014 pass  out  1  run finished with no mismatches and no timeout.
REQ-015 err_cnt  out  ADDR_W+1  mismatch count, 0..DEPTH.
REQ-016 first_err_idx  out  ADDR_W  beat index of the first mismatch.
REQ-017 first_err_valid  out  1  first_err_idx holds a captured value.
REQ-018 timeout  out  1  run aborted by the idle timeout.

Function
REQ-019 FSM SHALL have states IDLE, RUN, DONE; DONE exits only on start.
REQ-020 IDLE/DONE + start SHALL go to RUN and clear idx, err_cnt, first_err_*, timeout, done, pass, and the idle counter.
REQ-021 start in RUN SHALL be ignored.
REQ-022 gold_addr SHALL equal idx combinationally at all times.
REQ-023 In RUN, s_tvalid=1 SHALL capture s_tdata and idx into stage-1, then increment idx.
REQ-024 A captured beat SHALL be compared against gold_data in the following cycle, giving 2-cycle latency from beat to counter update.
REQ-025 Match SHALL be true for any of: bit-identical; both NaN (exp=0xFF, mant!=0); both zero of either sign; same sign, neither NaN/Inf, and |a[30:0]-b[30:0]| <= ULP_TOL.
REQ-026 Inf SHALL match only an identically signed Inf.
REQ-027 On a mismatch, err_cnt SHALL increment and saturate at DEPTH.
REQ-028 On the first mismatch only, first_err_idx SHALL be set to the beat index and first_err_valid set to 1.
REQ-029 When the beat with idx=DEPTH-1 is accepted, idx SHALL wrap to 0 and further beats SHALL be ignored.
REQ-030 After the compare of the beat with idx=DEPTH-1, the FSM SHALL enter DONE and assert done.
REQ-031 The idle counter SHALL increment on each RUN cycle without s_tvalid and clear on an accepted beat.
REQ-032 When the idle counter reaches TIMEOUT, timeout SHALL assert, the FSM SHALL enter DONE, and any in-flight compare SHALL complete first.
REQ-033 s_tvalid in IDLE or DONE SHALL be ignored.
REQ-034 pass SHALL equal done AND err_cnt==0 AND NOT timeout.
REQ-035 busy SHALL be 1 exactly in RUN, or while a compare is in flight.

Reset
REQ-036 rst_n=0 SHALL force IDLE and drive busy, done, pass, err_cnt, first_err_idx, first_err_valid, timeout and idx to 0.
REQ-037 Reset mid-run SHALL discard the in-flight beat, with no counter update after reset release.

Structure
REQ-038 Package floating_point_check_pkg SHALL hold the FSM state type and the FP field constants (EXP_MAX 0xFF, sign/exp/mantissa positions).
REQ-039 Match logic SHALL be a combinational sub-module, floating_point_ulp_compare (a, b, ULP_TOL -> match).
REQ-040 Total RTL SHALL be 120-400 lines.

Verification
REQ-041 start, then 32 beats on consecutive cycles equal to the ROM contents -> done=1 two cycles after the last beat, pass=1, err_cnt=0, first_err_valid=0.
REQ-042 Beats 7 and 20 corrupted by flipping bit 31 -> err_cnt=2, first_err_idx=7, pass=0.
REQ-043 ULP_TOL=1, beat 3 = gold+1 ULP and beat 4 = gold+2 ULP -> err_cnt=1, first_err_idx=4; gold 0x7FC00000 vs result 0x7FC00001 -> match; 0x00000000 vs 0x80000000 -> match; 0x7F800000 vs 0xFF800000 -> mismatch.
REQ-044 TIMEOUT=16, 10 beats then silence -> timeout=1 and done=1 exactly 16 idle cycles after the last beat, pass=0; a subsequent start clears all flags.
REQ-045 Beats in IDLE, a 33rd beat, and start in RUN -> all ignored, err_cnt unchanged.
REQ-046 rst_n=0 at beat 15 -> all outputs 0 the next cycle; a fresh start yields a normal 32-beat pass.
